// File: rtl/pcie_rc_pkg.sv
// ---------------------------------------------------------------------------
// pcie_rc_pkg
// Shared definitions for the root-complex config request path:
//   - controller request-type encodings (cfg0/cfg1, read/write)
//   - RQ descriptor request-type codes and descriptor field positions
//   - requester TX FSM state encodings
//   - RQ tuser bit offsets (512-bit straddle-capable layout)
// ---------------------------------------------------------------------------
package pcie_rc_pkg;

    typedef enum logic [1:0] {
        REQ_CFG0_RD = 2'b00,
        REQ_CFG0_WR = 2'b01,
        REQ_CFG1_RD = 2'b10,
        REQ_CFG1_WR = 2'b11
    } req_type_e;

    localparam logic [3:0] RQ_CFG0_RD = 4'b1000;
    localparam logic [3:0] RQ_CFG0_WR = 4'b1001;
    localparam logic [3:0] RQ_CFG1_RD = 4'b1010;
    localparam logic [3:0] RQ_CFG1_WR = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Descriptor field LSB positions (tdata[127:0])
    localparam int DESC_ADDR_LSB    = 2;
    localparam int DESC_DWCNT_LSB   = 64;
    localparam int DESC_REQTYPE_LSB = 75;
    localparam int DESC_RID_LSB     = 80;
    localparam int DESC_TAG_LSB     = 96;
    localparam int DESC_CID_LSB     = 104;
    localparam int DESC_RID_EN_BIT  = 120;
    localparam int DESC_PAYLOAD_LSB = 128;

    // tuser bit offsets
    localparam int TUSER_FIRST_BE_LSB = 0;
    localparam int TUSER_IS_SOP_LSB   = 20;
    localparam int TUSER_IS_EOP_LSB   = 26;
    localparam int TUSER_EOP0_PTR_LSB = 28;

    // Request-type code is the controller encoding prefixed with 2'b10.
    function automatic logic [3:0] rq_code(input logic [1:0] req_type);
        return {2'b10, req_type};
    endfunction

    function automatic logic is_write(input logic [1:0] req_type);
        return req_type[0];
    endfunction

endpackage

// File: rtl/pcie_rq_desc_build.sv
// ---------------------------------------------------------------------------
// pcie_rq_desc_build
// Combinational formatter: turns one config request into a single-beat RQ
// descriptor (tdata), DW keep mask (tkeep) and sideband (tuser).
// Ports:
//   req_type      in   2            cfg0/cfg1 read/write
//   req_bdf       in   16           completer bus/dev/fn
//   req_reg_addr  in   12           byte address ([11:2] used)
//   req_first_be  in   4            first-DW byte enables
//   req_wdata     in   32           write payload
//   tag           in   8            tag to place in the descriptor
//   tdata         out  C_DATA_WIDTH descriptor + payload
//   tuser         out  TUSER_WIDTH  sideband
//   tkeep         out  KEEP_WIDTH   DW valid mask
// ---------------------------------------------------------------------------
module pcie_rq_desc_build
    import pcie_rc_pkg::*;
#(
    parameter int          C_DATA_WIDTH  = 512,
    parameter int          KEEP_WIDTH    = C_DATA_WIDTH / 32,
    parameter int          TUSER_WIDTH   = 137,
    parameter logic [15:0] RP_BUS_DEV_FN = 16'h0000
) (
    input  logic [1:0]              req_type,
    input  logic [15:0]             req_bdf,
    input  logic [11:0]             req_reg_addr,
    input  logic [3:0]              req_first_be,
    input  logic [31:0]             req_wdata,
    input  logic [7:0]              tag,
    output logic [C_DATA_WIDTH-1:0] tdata,
    output logic [TUSER_WIDTH-1:0]  tuser,
    output logic [KEEP_WIDTH-1:0]   tkeep
);

    // Config addresses are DW aligned; the byte offset bits carry no meaning.
    logic [1:0] unused_addr_bits;
    assign unused_addr_bits = req_reg_addr[1:0];

    // NOTE: every output gets a full default first so no path leaves a bit
    // unassigned and no latch is inferred.
    always_comb begin
        tdata = '0;
        tuser = '0;
        tkeep = '0;

        tdata[DESC_ADDR_LSB +: 10]    = req_reg_addr[11:2];
        tdata[DESC_DWCNT_LSB +: 11]   = 11'd1;
        tdata[DESC_REQTYPE_LSB +: 4]  = rq_code(req_type);
        tdata[DESC_RID_LSB +: 16]     = RP_BUS_DEV_FN;
        tdata[DESC_TAG_LSB +: 8]      = tag;
        tdata[DESC_CID_LSB +: 16]     = req_bdf;
        tdata[DESC_RID_EN_BIT]        = 1'b1;

        // Four descriptor DWs always; writes append the single payload DW.
        tkeep[3:0] = 4'hF;
        if (is_write(req_type)) begin
            tdata[DESC_PAYLOAD_LSB +: 32] = req_wdata;
            tkeep[4]                      = 1'b1;
        end

        tuser[TUSER_FIRST_BE_LSB +: 4] = req_first_be;
        // The 512-bit interface needs explicit SOP/EOP framing; the 256-bit
        // one relies on tlast alone.
        if (C_DATA_WIDTH == 512) begin
            tuser[TUSER_IS_SOP_LSB +: 2]   = 2'b01;
            tuser[TUSER_IS_EOP_LSB +: 2]   = 2'b01;
            tuser[TUSER_EOP0_PTR_LSB +: 4] = is_write(req_type) ? 4'd4 : 4'd3;
        end
    end

endmodule

// File: rtl/pcie_rq_cfg_tx.sv
// ---------------------------------------------------------------------------
// pcie_rq_cfg_tx
// Root-complex requester TX engine. Accepts one config request (Type0/Type1,
// read/write) from the enumeration controller and emits it as a single-beat
// RQ descriptor on s_axis_rq, honouring tready. Reports completion of the
// handshake (done/done_tag) or loss of link before acceptance (abort).
// Ports:
//   user_clk / user_reset_n   clock, synchronous active-low reset
//   user_lnk_up               link status from the IP
//   req_*                     request from the controller (valid/ready)
//   s_axis_rq_*               RQ stream to the IP
//   done / done_tag           1-cycle pulse + tag when the IP takes the beat
//   abort                     1-cycle pulse when the link drops mid-send
// ---------------------------------------------------------------------------
module pcie_rq_cfg_tx
    import pcie_rc_pkg::*;
#(
    parameter int          C_DATA_WIDTH                      = 512,
    parameter int          KEEP_WIDTH                        = C_DATA_WIDTH / 32,
    parameter int          TUSER_WIDTH                       = 137,
    parameter int          ATTR_AXISTEN_IF_ENABLE_CLIENT_TAG = 0,
    parameter logic [15:0] RP_BUS_DEV_FN                     = 16'h0000
) (
    input  logic                    user_clk,
    input  logic                    user_reset_n,
    input  logic                    user_lnk_up,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_type,
    input  logic [15:0]             req_bdf,
    input  logic [11:0]             req_reg_addr,
    input  logic [3:0]              req_first_be,
    input  logic [31:0]             req_wdata,
    input  logic [7:0]              req_tag,
    output logic [C_DATA_WIDTH-1:0] s_axis_rq_tdata,
    output logic [TUSER_WIDTH-1:0]  s_axis_rq_tuser,
    output logic [KEEP_WIDTH-1:0]   s_axis_rq_tkeep,
    output logic                    s_axis_rq_tlast,
    output logic                    s_axis_rq_tvalid,
    input  logic                    s_axis_rq_tready,
    output logic                    done,
    output logic [7:0]              done_tag,
    output logic                    abort
);

    state_e                  state_q, state_d;
    logic [7:0]              tag_cnt_q;
    logic [7:0]              sent_tag_q;
    logic [7:0]              tag_sel;
    logic                    accept;
    logic                    load_beat;
    logic                    tvalid_d;
    logic                    abort_d;
    logic [C_DATA_WIDTH-1:0] tdata_q, tdata_c;
    logic [TUSER_WIDTH-1:0]  tuser_q, tuser_c;
    logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_c;
    logic                    tvalid_q;
    logic                    abort_q;

    assign tag_sel = (ATTR_AXISTEN_IF_ENABLE_CLIENT_TAG != 0) ? req_tag : tag_cnt_q;

    // Ready is also held low during reset so nothing is offered to the
    // controller before the engine is running.
    assign req_ready = user_reset_n && user_lnk_up && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    pcie_rq_desc_build #(
        .C_DATA_WIDTH (C_DATA_WIDTH),
        .KEEP_WIDTH   (KEEP_WIDTH),
        .TUSER_WIDTH  (TUSER_WIDTH),
        .RP_BUS_DEV_FN(RP_BUS_DEV_FN)
    ) u_desc_build (
        .req_type    (req_type),
        .req_bdf     (req_bdf),
        .req_reg_addr(req_reg_addr),
        .req_first_be(req_first_be),
        .req_wdata   (req_wdata),
        .tag         (tag_sel),
        .tdata       (tdata_c),
        .tuser       (tuser_c),
        .tkeep       (tkeep_c)
    );

    always_comb begin
        state_d   = state_q;
        load_beat = 1'b0;
        tvalid_d  = tvalid_q;
        abort_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SEND;
                    load_beat = 1'b1;
                    tvalid_d  = 1'b1;
                end
            end
            ST_SEND: begin
                // Link loss wins over a same-cycle tready: the IP cannot be
                // trusted to have taken the beat once the link is down.
                if (!user_lnk_up) begin
                    state_d  = ST_IDLE;
                    tvalid_d = 1'b0;
                    abort_d  = 1'b1;
                end else if (s_axis_rq_tready) begin
                    state_d  = ST_DONE;
                    tvalid_d = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                tvalid_d = 1'b0;
            end
        endcase
    end

    // NOTE: the wide beat registers are cleared on reset because the IP-facing
    // bus must read as zero while the engine is held in reset.
    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            state_q    <= ST_IDLE;
            tag_cnt_q  <= '0;
            sent_tag_q <= '0;
            tdata_q    <= '0;
            tuser_q    <= '0;
            tkeep_q    <= '0;
            tvalid_q   <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q  <= state_d;
            tvalid_q <= tvalid_d;
            abort_q  <= abort_d;
            if (load_beat) begin
                tdata_q    <= tdata_c;
                tuser_q    <= tuser_c;
                tkeep_q    <= tkeep_c;
                sent_tag_q <= tag_sel;
            end
            // Counter advances only for requests the IP actually took.
            if (state_q == ST_DONE && ATTR_AXISTEN_IF_ENABLE_CLIENT_TAG == 0) begin
                tag_cnt_q <= tag_cnt_q + 8'd1;
            end
        end
    end

    assign s_axis_rq_tdata  = tdata_q;
    assign s_axis_rq_tuser  = tuser_q;
    assign s_axis_rq_tkeep  = tkeep_q;
    assign s_axis_rq_tvalid = tvalid_q;
    assign s_axis_rq_tlast  = tvalid_q;
    assign done             = (state_q == ST_DONE);
    assign done_tag         = (state_q == ST_DONE) ? sent_tag_q : 8'h00;
    assign abort            = abort_q;

endmodule

// File: tb/tb_pcie_rq_cfg_tx.sv
// ---------------------------------------------------------------------------
// tb_pcie_rq_cfg_tx
// Self-checking bench. Two engines share one request/stream input set:
//   dut_a : 512-bit, internal tag counter
//   dut_b : 256-bit, client tag
// Expected beats are pushed to a scoreboard queue when a request is issued
// and compared while the beat is on the bus and when it is accepted.
// ---------------------------------------------------------------------------
module tb_pcie_rq_cfg_tx;

    localparam logic [15:0] RPID = 16'h0008;

    logic         user_clk = 1'b0;
    logic         user_reset_n;
    logic         user_lnk_up;
    logic         req_valid;
    logic [1:0]   req_type;
    logic [15:0]  req_bdf;
    logic [11:0]  req_reg_addr;
    logic [3:0]   req_first_be;
    logic [31:0]  req_wdata;
    logic [7:0]   req_tag;
    logic         tready;

    logic         a_req_ready, a_tlast, a_tvalid, a_done, a_abort;
    logic [511:0] a_tdata;
    logic [136:0] a_tuser;
    logic [15:0]  a_tkeep;
    logic [7:0]   a_done_tag;

    logic         b_req_ready, b_tlast, b_tvalid, b_done, b_abort;
    logic [255:0] b_tdata;
    logic [61:0]  b_tuser;
    logic [7:0]   b_tkeep;
    logic [7:0]   b_done_tag;

    always #5 user_clk = ~user_clk;

    pcie_rq_cfg_tx #(
        .C_DATA_WIDTH(512), .KEEP_WIDTH(16), .TUSER_WIDTH(137),
        .ATTR_AXISTEN_IF_ENABLE_CLIENT_TAG(0), .RP_BUS_DEV_FN(RPID)
    ) dut_a (
        .user_clk(user_clk), .user_reset_n(user_reset_n), .user_lnk_up(user_lnk_up),
        .req_valid(req_valid), .req_ready(a_req_ready), .req_type(req_type),
        .req_bdf(req_bdf), .req_reg_addr(req_reg_addr), .req_first_be(req_first_be),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .s_axis_rq_tdata(a_tdata), .s_axis_rq_tuser(a_tuser), .s_axis_rq_tkeep(a_tkeep),
        .s_axis_rq_tlast(a_tlast), .s_axis_rq_tvalid(a_tvalid), .s_axis_rq_tready(tready),
        .done(a_done), .done_tag(a_done_tag), .abort(a_abort)
    );

    pcie_rq_cfg_tx #(
        .C_DATA_WIDTH(256), .KEEP_WIDTH(8), .TUSER_WIDTH(62),
        .ATTR_AXISTEN_IF_ENABLE_CLIENT_TAG(1), .RP_BUS_DEV_FN(RPID)
    ) dut_b (
        .user_clk(user_clk), .user_reset_n(user_reset_n), .user_lnk_up(user_lnk_up),
        .req_valid(req_valid), .req_ready(b_req_ready), .req_type(req_type),
        .req_bdf(req_bdf), .req_reg_addr(req_reg_addr), .req_first_be(req_first_be),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .s_axis_rq_tdata(b_tdata), .s_axis_rq_tuser(b_tuser), .s_axis_rq_tkeep(b_tkeep),
        .s_axis_rq_tlast(b_tlast), .s_axis_rq_tvalid(b_tvalid), .s_axis_rq_tready(tready),
        .done(b_done), .done_tag(b_done_tag), .abort(b_abort)
    );

    typedef struct {
        logic [1:0]  rtype;
        logic [15:0] bdf;
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          stall;
        logic [3:0]  code;   // expected descriptor req type
        logic [15:0] keep;   // expected tkeep
        logic [3:0]  ptr;    // expected eop0 pointer
        logic        wr;     // payload expected in tdata[159:128]
    } vec_t;

    typedef struct {
        logic [511:0] tdata;
        logic [136:0] tuser;
        logic [15:0]  tkeep;
        logic [7:0]   tag;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] tag_model = 8'h00;
    logic       pend = 1'b0;
    logic [7:0] pend_tag = 8'h00;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input vec_t v, input logic [7:0] tag);
        exp_t e;
        e.tdata           = '0;
        e.tdata[11:2]     = v.addr[11:2];
        e.tdata[74:64]    = 11'd1;
        e.tdata[78:75]    = v.code;
        e.tdata[95:80]    = RPID;
        e.tdata[103:96]   = tag;
        e.tdata[119:104]  = v.bdf;
        e.tdata[120]      = 1'b1;
        if (v.wr) e.tdata[159:128] = v.wdata;
        e.tuser           = '0;
        e.tuser[3:0]      = v.be;
        e.tuser[21:20]    = 2'b01;
        e.tuser[27:26]    = 2'b01;
        e.tuser[31:28]    = v.ptr;
        e.tkeep           = v.keep;
        e.tag             = tag;
        return e;
    endfunction

    // Stream monitor for dut_a, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge user_clk);
            if (pend) begin
                check("done pulse", {511'd0, a_done}, 512'd1);
                check("done_tag", {504'd0, a_done_tag}, {504'd0, pend_tag});
                pend = 1'b0;
            end else if (a_done) begin
                check("unexpected done", {511'd0, a_done}, 512'd0);
            end
            if (a_tvalid) begin
                if (sb.size() == 0) begin
                    check("beat with no request", {511'd0, a_tvalid}, 512'd0);
                end else begin
                    check("tdata", a_tdata, sb[0].tdata);
                    check("tuser", {375'd0, a_tuser}, {375'd0, sb[0].tuser});
                    check("tkeep", {496'd0, a_tkeep}, {496'd0, sb[0].tkeep});
                    check("tlast", {511'd0, a_tlast}, 512'd1);
                    if (tready && user_lnk_up) begin
                        pend     = 1'b1;
                        pend_tag = sb[0].tag;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic drive_req(input vec_t v);
        req_type     = v.rtype;
        req_bdf      = v.bdf;
        req_reg_addr = v.addr;
        req_first_be = v.be;
        req_wdata    = v.wdata;
        req_valid    = 1'b1;
    endtask

    // Waits (bounded) for req_ready, then lets the next edge accept the request.
    task automatic accept_req(input vec_t v, input logic [7:0] tag);
        int n = 0;
        drive_req(v);
        while (!a_req_ready && n < 20) begin
            step();
            n++;
        end
        check("req_ready before accept", {511'd0, a_req_ready}, 512'd1);
        sb.push_back(model(v, tag));
        step();
        req_valid = 1'b0;
        check("tvalid one cycle after accept", {511'd0, a_tvalid}, 512'd1);
        check("req_ready low in SEND", {511'd0, a_req_ready}, 512'd0);
    endtask

    // Full request: accept, stall tready, wait for done.
    task automatic issue(input vec_t v, input bit chk_b);
        int n = 0;
        tready = (v.stall == 0);
        accept_req(v, tag_model);
        if (chk_b) begin
            check("b tdata tag", {504'd0, b_tdata[103:96]}, {504'd0, req_tag});
            check("b tdata type", {508'd0, b_tdata[78:75]}, {508'd0, v.code});
            check("b tuser", {450'd0, b_tuser}, {508'd0, v.be});
            check("b tkeep", {504'd0, b_tkeep}, {496'd0, v.keep});
            check("b tlast", {511'd0, b_tlast}, 512'd1);
        end
        repeat (v.stall) step();
        tready = 1'b1;
        while (!a_done && n < 20) begin
            step();
            n++;
        end
        check("done latency after handshake", n, 1);
        check("req_ready low in DONE", {511'd0, a_req_ready}, 512'd0);
        if (chk_b) begin
            check("b done", {511'd0, b_done}, 512'd1);
            check("b done_tag", {504'd0, b_done_tag}, {504'd0, req_tag});
        end
        tag_model = tag_model + 8'd1;
    endtask

    vec_t tbl[5];
    vec_t rd1;

    initial begin
        tbl[0] = '{2'b00, 16'h0100, 12'h010, 4'hF, 32'h0,        0, 4'b1000, 16'h0F, 4'd3, 1'b0};
        tbl[1] = '{2'b11, 16'h0208, 12'h0FC, 4'hF, 32'hDEADBEEF, 5, 4'b1011, 16'h1F, 4'd4, 1'b1};
        tbl[2] = '{2'b01, 16'h0000, 12'h004, 4'h3, 32'h12345678, 1, 4'b1001, 16'h1F, 4'd4, 1'b1};
        tbl[3] = '{2'b10, 16'hFFFF, 12'hFFF, 4'h8, 32'hFFFFFFFF, 2, 4'b1010, 16'h0F, 4'd3, 1'b0};
        tbl[4] = '{2'b00, 16'h1234, 12'h003, 4'h1, 32'h0,        0, 4'b1000, 16'h0F, 4'd3, 1'b0};
        rd1    = tbl[0];

        user_reset_n = 1'b0;
        user_lnk_up  = 1'b1;
        req_valid    = 1'b0;
        req_type     = 2'b00;
        req_bdf      = 16'h0;
        req_reg_addr = 12'h0;
        req_first_be = 4'h0;
        req_wdata    = 32'h0;
        req_tag      = 8'h00;
        tready       = 1'b0;

        // Reset state
        repeat (3) step();
        check("reset req_ready", {510'd0, a_req_ready, b_req_ready}, 512'd0);
        check("reset tvalid", {510'd0, a_tvalid, b_tvalid}, 512'd0);
        check("reset tlast", {511'd0, a_tlast}, 512'd0);
        check("reset tdata", a_tdata, 512'd0);
        check("reset tuser", {375'd0, a_tuser}, 512'd0);
        check("reset tkeep", {496'd0, a_tkeep}, 512'd0);
        check("reset done/abort", {510'd0, a_done, a_abort}, 512'd0);
        check("reset done_tag", {504'd0, a_done_tag}, 512'd0);
        user_reset_n = 1'b1;
        step();
        check("req_ready after reset", {511'd0, a_req_ready}, 512'd1);

        // Table-driven requests (cfg0/cfg1, read/write, varying stalls)
        for (int i = 0; i < 5; i++) issue(tbl[i], 1'b0);

        // Link drop during SEND with tready high in the same cycle
        tready = 1'b0;
        accept_req(rd1, tag_model);
        step();
        user_lnk_up = 1'b0;
        tready      = 1'b1;
        step();
        check("abort pulse", {510'd0, a_abort, b_abort}, {510'd0, 2'b11});
        check("tvalid dropped on abort", {511'd0, a_tvalid}, 512'd0);
        check("no done on abort", {511'd0, a_done}, 512'd0);
        check("req_ready low with link down", {511'd0, a_req_ready}, 512'd0);
        void'(sb.pop_front());
        step();
        check("abort is one cycle", {511'd0, a_abort}, 512'd0);
        check("still no done after abort", {511'd0, a_done}, 512'd0);
        check("req_ready low while link down", {511'd0, a_req_ready}, 512'd0);
        user_lnk_up = 1'b1;
        #1;
        check("req_ready on link up", {511'd0, a_req_ready}, 512'd1);

        // Reset in the middle of SEND
        tready = 1'b0;
        accept_req(tbl[1], tag_model);
        user_reset_n = 1'b0;
        step();
        check("mid-send reset tvalid", {510'd0, a_tvalid, b_tvalid}, 512'd0);
        check("mid-send reset tdata", a_tdata, 512'd0);
        check("mid-send reset tkeep/tuser", {359'd0, a_tkeep, a_tuser}, 512'd0);
        check("mid-send reset done/abort", {510'd0, a_done, a_abort}, 512'd0);
        sb.delete();
        user_reset_n = 1'b1;
        tag_model    = 8'h00;
        step();
        issue(rd1, 1'b0);

        // 256-bit client-tag engine, tag A5
        req_tag = 8'hA5;
        issue(tbl[4], 1'b1);
        req_tag = 8'h00;

        // Back-to-back reads: tag counter walks through the 255 -> 0 wrap
        rd1.bdf  = 16'h0300;
        rd1.addr = 12'h040;
        for (int i = 0; i < 257; i++) issue(rd1, 1'b0);

        step();
        step();
        check("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
